regfile_write_sequencer: RTL and testbench

- Owns the single write port (A3/WD3/WE3) of the 32x32 register file.
- After reset, zeroes x1..x31 with a hardware clear sequence.
- Then arbitrates the port round-robin between two writers: req0 (core writeback) and req1 (load/debug unit), each using a valid/ready handshake.
- Writes to x0 are suppressed; x0 stays hard-wired zero.

---
 rtl/regfile_write_sequencer_if.sv | 35 +++
 rtl/regfile_write_sequencer.sv | 105 ++++++++++
 tb/tb_regfile_write_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_sequencer_if.sv
// Write-port bundle between the two register-file writers, the sequencer
// and the register file write port.
interface regfile_write_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              WE3;
  logic [ADDR_W-1:0] A3;
  logic [DATA_W-1:0] WD3;
  logic              init_done;

  // Writer side (and observer of the register-file port)
  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  WE3, A3, WD3, init_done
  );

  // Sequencer side
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output WE3, A3, WD3, init_done
  );
endinterface

// File: rtl/regfile_write_sequencer.sv
// Owns the register-file write port: clears x1..x(NUM_REGS-1) after reset,
// then grants the port round-robin to two valid/ready writers. x0 writes
// complete the handshake but never assert WE3.
module regfile_write_sequencer #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter int NUM_REGS       = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic                       clk,
  input logic                       reset,
  regfile_write_sequencer_if.slave  bus
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NUM_REGS - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rr_q, rr_d;
  logic              gnt0, gnt1;

  logic              we3_p0, we3_d;
  logic [ADDR_W-1:0] a3_p0, a3_d;
  logic [DATA_W-1:0] wd3_p0, wd3_d;
  logic              done_p0, done_d;

  // Next-state, grant and write-port staging
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    we3_d   = 1'b0;
    a3_d    = a3_p0;
    wd3_d   = wd3_p0;
    done_d  = done_p0;
    case (state_q)
      CLEAR: begin
        we3_d = 1'b1;
        a3_d  = cnt_q[ADDR_W-1:0];
        wd3_d = '0;
        cnt_d = cnt_q + CNT_FIRST;
        if (cnt_q == CNT_LAST) begin
          state_d = RUN;
          done_d  = 1'b1;
        end
      end
      RUN: begin
        done_d = 1'b1;
        // rr_q = 0 favours writer 0 when both are pending
        if (bus.req0_valid && (!bus.req1_valid || !rr_q)) begin
          gnt0 = 1'b1;
        end else if (bus.req1_valid) begin
          gnt1 = 1'b1;
        end
        if (gnt0) begin
          a3_d  = bus.req0_addr;
          wd3_d = bus.req0_data;
          we3_d = (bus.req0_addr != '0);
          rr_d  = 1'b1;
        end else if (gnt1) begin
          a3_d  = bus.req1_addr;
          wd3_d = bus.req1_data;
          we3_d = (bus.req1_addr != '0);
          rr_d  = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State, pointer, counter and registered write-port outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      cnt_q   <= CNT_FIRST;
      rr_q    <= 1'b0;
      we3_p0  <= 1'b0;
      a3_p0   <= '0;
      wd3_p0  <= '0;
      done_p0 <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      we3_p0  <= we3_d;
      a3_p0   <= a3_d;
      wd3_p0  <= wd3_d;
      done_p0 <= done_d;
    end
  end

  assign bus.req0_ready = gnt0 && !reset;
  assign bus.req1_ready = gnt1 && !reset;
  assign bus.WE3        = we3_p0;
  assign bus.A3         = a3_p0;
  assign bus.WD3        = wd3_p0;
  assign bus.init_done  = done_p0;

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Scoreboard bench for regfile_write_sequencer with a reference model of
// the clear sweep, round-robin arbitration and a behavioural register file.
module tb_regfile_write_sequencer;

  logic clk;
  logic reset;

  regfile_write_sequencer_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_write_sequencer #(
    .DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .CLEAR_ON_RESET(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          due;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    bit          last;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          vectors;
  int          miscompares;
  int          edge_cnt;
  bit          in_run;
  int          clr_left;
  bit          ptr;
  logic [4:0]  held_a;
  logic [31:0] held_wd;
  logic        exp_done;
  logic [31:0] rf     [32];
  logic [31:0] ref_rf [32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file fed by the sequencer's write port
  always @(posedge clk) begin
    if (bus.WE3 && bus.A3 != 5'd0) rf[bus.A3] <= bus.WD3;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: compares the write port after every edge
  always @(posedge clk) begin
    edge_cnt++;
    #1;
    if (reset) begin
      check("reset_state", {bus.WE3, bus.A3, bus.WD3, bus.init_done}, 64'd0);
      held_a   = '0;
      held_wd  = '0;
      exp_done = 1'b0;
    end else if (q.size() > 0 && q[0].due == edge_cnt) begin
      e = q.pop_front();
      held_a  = e.addr;
      held_wd = e.data;
      if (e.last) exp_done = 1'b1;
      check("write_port", {bus.WE3, bus.A3, bus.WD3}, {e.we, e.addr, e.data});
      check("init_done", bus.init_done, exp_done);
    end else begin
      if (q.size() > 0 && q[0].due < edge_cnt) begin
        check("stale_entry", q[0].due, edge_cnt);
        void'(q.pop_front());
      end
      check("idle_port", {bus.WE3, bus.A3, bus.WD3, bus.init_done},
            {1'b0, held_a, held_wd, exp_done});
    end
  end

  task automatic set_inputs(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                            input bit v1, input logic [4:0] a1, input logic [31:0] d1);
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
  endtask

  task automatic reset_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      reset = 1'b1;
      set_inputs(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom), $urandom);
      q.delete();
      in_run = 1'b0;
      ptr    = 1'b0;
      #1;
      check("ready_in_reset", {bus.req0_ready, bus.req1_ready}, 2'b00);
    end
  endtask

  task automatic drive_cycle(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                             input bit v1, input logic [4:0] a1, input logic [31:0] d1);
    bit g0, g1;
    exp_t n;
    @(negedge clk);
    if (reset) begin
      reset = 1'b0;
      for (int i = 0; i < 31; i++) begin
        n.due = edge_cnt + 1 + i; n.we = 1'b1; n.addr = 5'(i + 1);
        n.data = '0; n.last = (i == 30);
        q.push_back(n);
      end
      for (int i = 0; i < 32; i++) ref_rf[i] = '0;
      clr_left = 31;
      in_run   = 1'b0;
    end
    set_inputs(v0, a0, d0, v1, a1, d1);
    #1;
    g0 = in_run && v0 && (!v1 || !ptr);
    g1 = in_run && v1 && !g0;
    check("ready", {bus.req0_ready, bus.req1_ready}, {g0, g1});
    if (g0 || g1) begin
      n.due  = edge_cnt + 1;
      n.addr = g0 ? a0 : a1;
      n.data = g0 ? d0 : d1;
      n.we   = (n.addr != 5'd0);
      n.last = 1'b0;
      q.push_back(n);
      if (n.addr != 5'd0) ref_rf[n.addr] = n.data;
      ptr = g0;
    end
    if (!in_run) begin
      clr_left--;
      if (clr_left == 0) in_run = 1'b1;
    end
  endtask

  task automatic random_cycles(input int n);
    repeat (n)
      drive_cycle(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom), $urandom);
  endtask

  initial begin
    vectors = 0; miscompares = 0; edge_cnt = 0;
    in_run = 1'b0; ptr = 1'b0; clr_left = 0;
    held_a = '0; held_wd = '0; exp_done = 1'b0;
    reset = 1'b1;
    set_inputs(1'b0, '0, '0, 1'b0, '0, '0);

    reset_cycles(2);
    // Initial sweep with writer 0 insisting
    repeat (31) drive_cycle(1'b1, 5'd7, 32'h1111_2222, 1'b0, '0, '0);

    // Single writer, then idle hold and readback
    drive_cycle(1'b1, 5'd10, 32'd12, 1'b0, '0, '0);
    drive_cycle(1'b0, '0, '0, 1'b0, '0, '0);
    drive_cycle(1'b0, '0, '0, 1'b0, '0, '0);
    check("readback_x10", rf[10], 32'd12);

    // Write to x0 from writer 1 flips priority back to writer 0
    drive_cycle(1'b0, '0, '0, 1'b1, 5'd0, 32'hDEAD_BEEF);
    drive_cycle(1'b0, '0, '0, 1'b0, '0, '0);

    // Contention: grants alternate 0,1,0,1
    repeat (4) drive_cycle(1'b1, 5'd20, 32'd15, 1'b1, 5'd30, 32'd12);
    drive_cycle(1'b0, '0, '0, 1'b0, '0, '0);
    drive_cycle(1'b0, '0, '0, 1'b0, '0, '0);
    check("readback_x20", rf[20], 32'd15);
    check("readback_x30", rf[30], 32'd12);

    random_cycles(300);

    // Reset in the middle of the clear sweep
    reset_cycles(1);
    repeat (14) drive_cycle(1'b1, 5'd3, 32'h5, 1'b1, 5'd4, 32'h6);
    reset_cycles(1);
    repeat (31) drive_cycle(1'b1, 5'd3, 32'h5, 1'b1, 5'd4, 32'h6);
    random_cycles(100);

    // Reset in the middle of RUN with traffic staged
    drive_cycle(1'b1, 5'd9, 32'hABCD_0001, 1'b1, 5'd11, 32'hABCD_0002);
    reset_cycles(2);
    random_cycles(31);
    random_cycles(150);

    repeat (3) drive_cycle(1'b0, '0, '0, 1'b0, '0, '0);
    check("queue_drained", q.size(), 0);
    for (int i = 1; i < 32; i++) check("rf_contents", rf[i], ref_rf[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
